tdm_link_mux: RTL and testbench

Parametrised N-channel, W-bit time-division multiplexer/demultiplexer pair. This is the clocked successor to the fixed 4:1 MUX / 1:4 DEMUX pair. The transmit half serialises N valid/ready input channels onto one link (data plus channel select) in either fixed-slot TDM or work-conserving round-robin mode. The receive half routes link words back to N registered output channels with per-channel strobes. The two halves share clock and reset only; they are looped back externally or joined through a link.

---
 rtl/tdm_link_mux.sv | 135 +++++++++++++
 tb/tb_tdm_link_mux.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tdm_link_mux.sv
// tdm_link_mux: N-channel TDM / round-robin link multiplexer plus registered link demultiplexer
// Ports:
//   clk, rst_n              sole clock (rising edge), asynchronous active-low reset
//   i_enable                1 = transmit scanner runs, 0 = freeze pointer and link word
//   i_mode                  0 = fixed-slot TDM, 1 = work-conserving round-robin
//   i_ch_in, i_ch_valid     transmit channels, channel i at bits [i*W +: W]
//   o_ch_ready              combinational one-hot accept for the granted channel
//   o_link_data/sel/valid   registered link word, its channel index and transfer flag
//   i_rx_data/sel/valid     received link word, channel index and valid
//   o_ch_out, o_ch_strobe   registered per-channel hold registers and one-cycle update pulses
//   o_err_count             saturating count of received words whose index is >= N
module tdm_link_mux #(
   parameter int N = 4,
   parameter int W = 4,
   localparam int SELW = (N > 2) ? $clog2(N) : 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            i_enable,
   input  logic            i_mode,
   input  logic [N*W-1:0]  i_ch_in,
   input  logic [N-1:0]    i_ch_valid,
   output logic [N-1:0]    o_ch_ready,
   output logic [W-1:0]    o_link_data,
   output logic [SELW-1:0] o_link_sel,
   output logic            o_link_valid,
   input  logic [W-1:0]    i_rx_data,
   input  logic [SELW-1:0] i_rx_sel,
   input  logic            i_rx_valid,
   output logic [N*W-1:0]  o_ch_out,
   output logic [N-1:0]    o_ch_strobe,
   output logic [7:0]      o_err_count
);
   logic [SELW-1:0] r_ptr;
   logic [W-1:0]    r_link_data;
   logic [SELW-1:0] r_link_sel;
   logic            r_link_valid;
   logic [N*W-1:0]  r_ch_out;
   logic [N-1:0]    r_ch_strobe;
   logic [7:0]      r_err_count;
   logic [SELW-1:0] w_grant;
   logic            w_grant_vld;
   logic            w_xfer;
   logic [W-1:0]    w_grant_data;
   logic [SELW-1:0] w_ptr_nxt;
   logic            w_rx_ok;

   function automatic logic [SELW-1:0] wrap_inc(input logic [SELW-1:0] x);
      return (x == SELW'(N - 1)) ? '0 : x + SELW'(1);
   endfunction

   always_comb begin
      logic [SELW:0] idx;
      w_grant_vld = 1'b0;
      w_grant     = r_ptr;
      idx         = '0;
      if (i_mode) begin
         // Scan from the far end back toward r_ptr so the nearest requester wins last
         for (int k = N - 1; k >= 0; k--) begin
            idx = {1'b0, r_ptr} + (SELW+1)'(k);
            if (idx >= (SELW+1)'(N)) idx = idx - (SELW+1)'(N);
            if (i_ch_valid[idx[SELW-1:0]]) begin
               w_grant_vld = 1'b1;
               w_grant     = idx[SELW-1:0];
            end
         end
      end else begin
         w_grant_vld = i_ch_valid[r_ptr];
      end
   end

   // rst_n gates the handshake so no source sees an accept while reset is held
   assign w_xfer = rst_n & i_enable & w_grant_vld;

   always_comb begin
      o_ch_ready   = '0;
      w_grant_data = '0;
      for (int i = 0; i < N; i++) begin
         if (w_grant == SELW'(i)) w_grant_data = i_ch_in[i*W +: W];
      end
      if (w_xfer) o_ch_ready[w_grant] = 1'b1;
   end

   assign w_ptr_nxt = !i_enable   ? r_ptr :
                      !i_mode     ? wrap_inc(r_ptr) :
                      w_grant_vld ? wrap_inc(w_grant) : r_ptr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr        <= '0;
         r_link_data  <= '0;
         r_link_sel   <= '0;
         r_link_valid <= 1'b0;
      end else begin
         r_ptr        <= w_ptr_nxt;
         r_link_valid <= w_xfer;
         if (w_xfer) begin
            r_link_data <= w_grant_data;
            r_link_sel  <= w_grant;
         end else if (i_enable && !i_mode) begin
            // An idle fixed slot still advertises which slot went by
            r_link_sel  <= r_ptr;
         end
      end
   end

   assign w_rx_ok = ({1'b0, i_rx_sel} < (SELW+1)'(N));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ch_out    <= '0;
         r_ch_strobe <= '0;
         r_err_count <= '0;
      end else begin
         r_ch_strobe <= '0;
         if (i_rx_valid && w_rx_ok) begin
            for (int i = 0; i < N; i++) begin
               if (i_rx_sel == SELW'(i)) begin
                  r_ch_out[i*W +: W] <= i_rx_data;
                  r_ch_strobe[i]     <= 1'b1;
               end
            end
         end else if (i_rx_valid && r_err_count != 8'hFF) begin
            r_err_count <= r_err_count + 8'd1;
         end
      end
   end

   assign o_link_data  = r_link_data;
   assign o_link_sel   = r_link_sel;
   assign o_link_valid = r_link_valid;
   assign o_ch_out     = r_ch_out;
   assign o_ch_strobe  = r_ch_strobe;
   assign o_err_count  = r_err_count;
endmodule

// File: tb/tb_tdm_link_mux.sv
// tb_tdm_link_mux: self-checking bench for tdm_link_mux (N=4 main instance, N=3 receive-error instance)
module tb_tdm_link_mux;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        en, mode, loop;
   logic [3:0]  valid;
   logic [15:0] chin;
   logic [3:0]  ready;
   logic [3:0]  ld;
   logic [1:0]  ls;
   logic        lv;
   logic [3:0]  rxd;
   logic [1:0]  rxs;
   logic        rxv;
   logic [3:0]  rx_d;
   logic [1:0]  rx_s;
   logic        rx_v;
   logic [15:0] chout;
   logic [3:0]  strobe;
   logic [7:0]  err;

   logic [3:0]  rxd3;
   logic [1:0]  rxs3;
   logic        rxv3;
   logic [2:0]  ready3;
   logic [3:0]  ld3;
   logic [1:0]  ls3;
   logic        lv3;
   logic [11:0] chout3;
   logic [2:0]  strobe3;
   logic [7:0]  err3;

   assign rx_d = loop ? ld : rxd;
   assign rx_s = loop ? ls : rxs;
   assign rx_v = loop ? lv : rxv;

   tdm_link_mux #(.N(4), .W(4)) u_dut (
      .clk(clk), .rst_n(rst_n), .i_enable(en), .i_mode(mode),
      .i_ch_in(chin), .i_ch_valid(valid), .o_ch_ready(ready),
      .o_link_data(ld), .o_link_sel(ls), .o_link_valid(lv),
      .i_rx_data(rx_d), .i_rx_sel(rx_s), .i_rx_valid(rx_v),
      .o_ch_out(chout), .o_ch_strobe(strobe), .o_err_count(err)
   );

   tdm_link_mux #(.N(3), .W(4)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .i_enable(1'b0), .i_mode(1'b0),
      .i_ch_in(12'h000), .i_ch_valid(3'b000), .o_ch_ready(ready3),
      .o_link_data(ld3), .o_link_sel(ls3), .o_link_valid(lv3),
      .i_rx_data(rxd3), .i_rx_sel(rxs3), .i_rx_valid(rxv3),
      .o_ch_out(chout3), .o_ch_strobe(strobe3), .o_err_count(err3)
   );

   int errors = 0;
   int checks = 0;

   // Reference model state: transmit pointer, link word, receive holds
   int m_ptr, m_ld, m_ls, m_lv;
   int m_out[4];
   int m_stb, m_err;
   int m3_out[3];
   int m3_stb, m3_err;
   int last_ready;

   typedef struct {
      logic        en;
      logic        mode;
      logic [3:0]  valid;
      logic [15:0] chin;
      logic [3:0]  rdy;
      logic [3:0]  ld;
      logic [1:0]  ls;
      logic        lv;
   } vec_t;
   vec_t tbl[14];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // First requester at or after ptr (round-robin) or ptr itself (fixed); -1 if none
   function automatic int grant_of(input int ptr, input bit md, input logic [3:0] v);
      if (!md) return v[ptr] ? ptr : -1;
      for (int k = 0; k < 4; k++)
         if (v[(ptr + k) % 4]) return (ptr + k) % 4;
      return -1;
   endfunction

   function automatic int pack4();
      int p = 0;
      for (int i = 0; i < 4; i++) p |= m_out[i] << (4 * i);
      return p;
   endfunction

   function automatic int pack3();
      int p = 0;
      for (int i = 0; i < 3; i++) p |= m3_out[i] << (4 * i);
      return p;
   endfunction

   task automatic model_reset();
      m_ptr = 0; m_ld = 0; m_ls = 0; m_lv = 0; m_stb = 0; m_err = 0;
      m3_stb = 0; m3_err = 0;
      for (int i = 0; i < 4; i++) m_out[i] = 0;
      for (int i = 0; i < 3; i++) m3_out[i] = 0;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, " ready"}, ready, 0);
      chk({tag, " link_data"}, ld, 0);
      chk({tag, " link_sel"}, ls, 0);
      chk({tag, " link_valid"}, lv, 0);
      chk({tag, " ch_out"}, chout, 0);
      chk({tag, " strobe"}, strobe, 0);
      chk({tag, " err"}, err, 0);
      chk({tag, " ch_out3"}, chout3, 0);
      chk({tag, " err3"}, err3, 0);
   endtask

   // Called at a negedge with inputs already driven; returns at the next negedge
   task automatic step();
      int g, rd, rs, rv;
      #1;
      g = en ? grant_of(m_ptr, mode, valid) : -1;
      last_ready = ready;
      chk("ch_ready", ready, g >= 0 ? (1 << g) : 0);
      chk("ch_ready3", ready3, 0);
      rd = loop ? m_ld : rxd;
      rs = loop ? m_ls : rxs;
      rv = loop ? m_lv : rxv;
      @(posedge clk);
      if (g >= 0) begin
         m_ld = chin[g*4 +: 4]; m_ls = g; m_lv = 1;
      end else begin
         m_lv = 0;
         if (en && !mode) m_ls = m_ptr;
      end
      if (en) begin
         if (!mode) m_ptr = (m_ptr + 1) % 4;
         else if (g >= 0) m_ptr = (g + 1) % 4;
      end
      m_stb = 0;
      if (rv) begin m_out[rs] = rd; m_stb = 1 << rs; end
      m3_stb = 0;
      if (rxv3) begin
         if (rxs3 < 3) begin m3_out[rxs3] = rxd3; m3_stb = 1 << rxs3; end
         else if (m3_err < 255) m3_err++;
      end
      #1;
      chk("link_data", ld, m_ld);
      chk("link_sel", ls, m_ls);
      chk("link_valid", lv, m_lv);
      chk("ch_out", chout, pack4());
      chk("ch_strobe", strobe, m_stb);
      chk("err_count", err, m_err);
      chk("ch_out3", chout3, pack3());
      chk("ch_strobe3", strobe3, m3_stb);
      chk("err_count3", err3, m3_err);
      chk("link_valid3", lv3, 0);
      chk("link_sel3", ls3, 0);
      chk("link_data3", ld3, 0);
      @(negedge clk);
   endtask

   initial begin
      int saved_sel, saved3;
      //                en  md  valid    chin      rdy      ld    ls  lv
      tbl[0]  = '{1'b1, 1'b0, 4'b0101, 16'hDCBA, 4'b0001, 4'hA, 2'd0, 1'b1};
      tbl[1]  = '{1'b1, 1'b0, 4'b0101, 16'hDCBA, 4'b0000, 4'hA, 2'd1, 1'b0};
      tbl[2]  = '{1'b1, 1'b0, 4'b0101, 16'hDCBA, 4'b0100, 4'hC, 2'd2, 1'b1};
      tbl[3]  = '{1'b1, 1'b0, 4'b0101, 16'hDCBA, 4'b0000, 4'hC, 2'd3, 1'b0};
      tbl[4]  = '{1'b1, 1'b0, 4'b0101, 16'hDCBA, 4'b0001, 4'hA, 2'd0, 1'b1};
      tbl[5]  = '{1'b1, 1'b1, 4'b1010, 16'hDCBA, 4'b0010, 4'hB, 2'd1, 1'b1};
      tbl[6]  = '{1'b1, 1'b1, 4'b1010, 16'hDCBA, 4'b1000, 4'hD, 2'd3, 1'b1};
      tbl[7]  = '{1'b1, 1'b1, 4'b1010, 16'hDCBA, 4'b0010, 4'hB, 2'd1, 1'b1};
      tbl[8]  = '{1'b1, 1'b1, 4'b1010, 16'hDCBA, 4'b1000, 4'hD, 2'd3, 1'b1};
      tbl[9]  = '{1'b1, 1'b1, 4'b0000, 16'hDCBA, 4'b0000, 4'hD, 2'd3, 1'b0};
      tbl[10] = '{1'b1, 1'b1, 4'b0000, 16'hDCBA, 4'b0000, 4'hD, 2'd3, 1'b0};
      tbl[11] = '{1'b1, 1'b1, 4'b1111, 16'hDCBA, 4'b0001, 4'hA, 2'd0, 1'b1};
      tbl[12] = '{1'b1, 1'b0, 4'b1111, 16'hDCBA, 4'b0010, 4'hB, 2'd1, 1'b1};
      tbl[13] = '{1'b1, 1'b1, 4'b0001, 16'hDCBA, 4'b0001, 4'hA, 2'd0, 1'b1};

      rst_n = 1'b0; en = 1'b0; mode = 1'b0; loop = 1'b0; valid = '0; chin = '0;
      rxd = '0; rxs = '0; rxv = 1'b0; rxd3 = '0; rxs3 = '0; rxv3 = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 chk_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Fixed-slot then round-robin vectors from a fresh pointer of 0
      for (int i = 0; i < 14; i++) begin
         en = tbl[i].en; mode = tbl[i].mode; valid = tbl[i].valid; chin = tbl[i].chin;
         step();
         chk($sformatf("vec%0d ready", i), last_ready, tbl[i].rdy);
         chk($sformatf("vec%0d link_data", i), ld, tbl[i].ld);
         chk($sformatf("vec%0d link_sel", i), ls, tbl[i].ls);
         chk($sformatf("vec%0d link_valid", i), lv, tbl[i].lv);
      end

      // Enable freeze during round-robin traffic (pointer is 1 here)
      mode = 1'b1; valid = 4'b1010;
      step(); step();
      chk("pre-freeze sel", ls, 3);
      saved_sel = ls;
      en = 1'b0;
      repeat (3) begin
         step();
         chk("freeze ready", last_ready, 0);
         chk("freeze valid", lv, 0);
         chk("freeze sel", ls, saved_sel);
      end
      en = 1'b1;
      step();
      chk("resume ready", last_ready, 4'b0010);
      chk("resume sel", ls, 1);

      // Loopback from a fresh pointer: strobe walks the channels two cycles behind
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      loop = 1'b1; mode = 1'b0; en = 1'b1; valid = 4'b1111; chin = 16'h963F;
      for (int i = 0; i < 6; i++) begin
         step();
         chk($sformatf("loop strobe%0d", i), strobe, i == 0 ? 0 : (1 << ((i - 1) % 4)));
      end
      chk("loop ch_out", chout, 16'h963F);

      // Asynchronous reset mid-stream, well away from any clock edge
      step();
      #2 rst_n = 1'b0;
      #1 chk_zero("async reset");
      @(negedge clk);
      chk_zero("held reset");
      rst_n = 1'b1;
      model_reset();
      loop = 1'b0; mode = 1'b1; valid = 4'b0000;
      repeat (3) begin
         step();
         chk("post-reset idle valid", lv, 0);
      end
      valid = 4'b1111;
      step();
      chk("post-reset ptr0 grant", last_ready, 4'b0001);

      // Random traffic against the model, including the N=3 receive side
      repeat (400) begin
         en = ($urandom_range(0, 3) != 0); mode = $urandom; valid = $urandom;
         chin = $urandom; rxd = $urandom; rxs = $urandom; rxv = $urandom;
         rxd3 = $urandom; rxs3 = $urandom; rxv3 = $urandom;
         step();
      end
      rxv = 1'b0;

      // N=3: out-of-range index only counts errors and must saturate
      rxv3 = 1'b1; rxs3 = 2'd1; rxd3 = 4'h5;
      step();
      saved3 = pack3();
      rxs3 = 2'd3; rxd3 = 4'hE;
      repeat (300) step();
      chk("n3 err saturated", err3, 255);
      chk("n3 ch_out unchanged", chout3, saved3);
      chk("n3 no strobe", strobe3, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
